// File: rtl/ariane_pkg.sv
// Shared issue/writeback types for functional units, including the serial bit-manipulation unit.
package ariane_pkg;

  localparam int unsigned FU_XLEN       = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  // Issue-to-writeback latency of bmu_serial, used by issue and scoreboard logic.
  localparam int unsigned BMU_LATENCY   = 65;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, BMU
  } fu_t;

  typedef enum logic [7:0] {
    ADD, SUB, ANDL, ORL, XORL, BEXT, BDEP, PCNT, CTZ, CLZ
  } fu_op;

  typedef struct packed {
    fu_t                      fu;
    fu_op                     operation;
    logic [FU_XLEN-1:0]       operand_a;
    logic [FU_XLEN-1:0]       operand_b;
    logic [FU_XLEN-1:0]       imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

endpackage

// File: rtl/bmu_serial.sv
// Bit-serial bit-manipulation unit: BEXT, BDEP, PCNT, CTZ, CLZ, one operand bit per cycle.
module bmu_serial
  import ariane_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  fu_data_t                 fu_data_i,
  input  logic                     bmu_valid_i,
  output logic                     bmu_ready_o,
  output logic [XLEN-1:0]          bmu_result_o,
  output logic [TRANS_ID_BITS-1:0] bmu_trans_id_o,
  output logic                     bmu_valid_o
);

  localparam int unsigned IDXW = $clog2(XLEN);
  localparam int unsigned KW   = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                   r_state;
  state_e                   w_next_state;
  fu_op                     r_op;
  logic [XLEN-1:0]          r_a;
  logic [XLEN-1:0]          r_b;
  logic [TRANS_ID_BITS-1:0] r_tid;
  logic [IDXW-1:0]          r_idx;
  logic [KW-1:0]            r_k;
  logic [XLEN-1:0]          r_acc;
  logic                     r_found;
  logic                     r_valid;
  logic [XLEN-1:0]          r_result;
  logic [TRANS_ID_BITS-1:0] r_tid_o;
  logic                     r_ready;

  logic                     w_accept;
  logic                     w_last;
  logic [KW-1:0]            w_k_nxt;
  logic [XLEN-1:0]          w_acc_nxt;
  logic                     w_found_nxt;
  logic [XLEN-1:0]          w_result;
  logic [IDXW-1:0]          w_k_idx;
  logic                     w_bit_a;
  logic                     w_bit_b;
  logic                     w_bit_clz;
  logic                     w_unused_fields;

  // Functional-unit select and immediate play no part in this unit.
  assign w_unused_fields = ^{fu_data_i.fu, fu_data_i.imm};

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state, accept decision and final-step detect; flush beats both accept and completion.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bmu_valid_i && !flush_i) begin
          w_accept     = 1'b1;
          w_next_state = RUN;
        end
      end
      RUN: begin
        if (flush_i) begin
          w_next_state = IDLE;
        end else if (r_idx == IDXW'(XLEN - 1)) begin
          w_last       = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // One serial step of the selected operation at bit position r_idx.
  always_comb begin
    w_k_idx     = r_k[IDXW-1:0];
    w_bit_a     = r_a[r_idx];
    w_bit_b     = r_b[r_idx];
    w_bit_clz   = r_a[IDXW'(XLEN - 1) - r_idx];
    w_k_nxt     = r_k;
    w_acc_nxt   = r_acc;
    w_found_nxt = r_found;
    w_result    = '0;
    case (r_op)
      BEXT: begin
        if (w_bit_b) begin
          w_acc_nxt[w_k_idx] = w_bit_a;
          w_k_nxt            = r_k + KW'(1);
        end
      end
      BDEP: begin
        if (w_bit_b) begin
          w_acc_nxt[r_idx] = r_a[w_k_idx];
          w_k_nxt          = r_k + KW'(1);
        end
      end
      PCNT: begin
        if (w_bit_a) w_k_nxt = r_k + KW'(1);
      end
      CTZ: begin
        if (!r_found) begin
          if (w_bit_a) w_found_nxt = 1'b1;
          else         w_k_nxt     = r_k + KW'(1);
        end
      end
      CLZ: begin
        if (!r_found) begin
          if (w_bit_clz) w_found_nxt = 1'b1;
          else           w_k_nxt     = r_k + KW'(1);
        end
      end
      default: ;
    endcase
    case (r_op)
      BEXT, BDEP:     w_result = w_acc_nxt;
      PCNT, CTZ, CLZ: w_result = XLEN'(w_k_nxt);
      default:        w_result = '0;
    endcase
  end

  // Operand capture on accept, then one bit of progress per RUN cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op    <= ADD;
      r_a     <= '0;
      r_b     <= '0;
      r_tid   <= '0;
      r_idx   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_found <= 1'b0;
    end else if (w_accept) begin
      r_op    <= fu_data_i.operation;
      r_a     <= XLEN'(fu_data_i.operand_a);
      r_b     <= XLEN'(fu_data_i.operand_b);
      r_tid   <= fu_data_i.trans_id;
      r_idx   <= '0;
      r_k     <= '0;
      r_acc   <= '0;
      r_found <= 1'b0;
    end else if (r_state == RUN) begin
      r_idx   <= r_idx + IDXW'(1);
      r_k     <= w_k_nxt;
      r_acc   <= w_acc_nxt;
      r_found <= w_found_nxt;
    end
  end

  // Writeback registers; result and tag hold between strobes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_tid_o  <= '0;
      r_ready  <= 1'b1;
    end else begin
      r_valid <= w_last;
      r_ready <= (w_next_state == IDLE);
      if (w_last) begin
        r_result <= w_result;
        r_tid_o  <= r_tid;
      end
    end
  end

  assign bmu_ready_o    = r_ready;
  assign bmu_result_o   = r_result;
  assign bmu_trans_id_o = r_tid_o;
  // A flush in the strobe cycle kills the writeback immediately.
  assign bmu_valid_o    = r_valid && !flush_i;

endmodule

// File: doc/bmu_serial.md
BMU_SERIAL -- requirements
Module: bmu_serial

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width.
REQ-002 SHALL have port clk_i  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  kill in-flight operation.
REQ-005 SHALL have port fu_data_i  input  fu_data_t  issued operation (operator, operand_a, operand_b, trans_id used; fu, imm ignored).
REQ-006 SHALL have port bmu_valid_i  input  1  issue request.
REQ-007 SHALL have port bmu_ready_o  output  1  unit idle, can accept.
REQ-008 SHALL have port bmu_result_o  output  XLEN  writeback data.
REQ-009 SHALL have port bmu_trans_id_o  output  TRANS_ID_BITS  scoreboard tag of result.
REQ-010 SHALL have port bmu_valid_o  output  1  one-cycle writeback strobe; no backpressure.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accept, RUN->DONE after idx=XLEN-1, DONE->IDLE unconditionally.
REQ-012 SHALL accept only when bmu_valid_i && bmu_ready_o; bmu_ready_o SHALL be 1 in IDLE only.
REQ-013 SHALL on accept latch operator, operand_a, operand_b, trans_id; clear idx, k counter (7 bit), accumulator.
REQ-014 SHALL process one bit per RUN cycle, idx 0..XLEN-1; fixed latency: accept in cycle 0, bmu_valid_o=1 in cycle XLEN+1 (65), ready_o=1 in cycle XLEN+2.
REQ-015 BEXT: if b[idx]=1 then res[k]=a[idx], k++.
REQ-016 BDEP: if b[idx]=1 then res[idx]=a[k], k++.
REQ-017 PCNT: count a[idx]=1; result zero-extended 7-bit count (all-ones -> 64).
REQ-018 CTZ: count bits below first 1 scanning idx upward; zero operand -> 64.
REQ-019 CLZ: same scan over a[XLEN-1-idx]; zero operand -> 64.
REQ-020 Any other operator SHALL be accepted, take identical latency, return result 0.
REQ-021 bmu_result_o and bmu_trans_id_o SHALL be valid only while bmu_valid_o=1; SHALL hold last value otherwise.
REQ-022 flush_i in RUN or DONE SHALL force IDLE next cycle, suppress bmu_valid_o in that cycle and after.
REQ-023 flush_i with bmu_valid_i in IDLE SHALL block accept (flush wins).
REQ-024 Operands SHALL NOT be resampled during RUN; fu_data_i changes mid-operation have no effect.

Reset
REQ-025 rst_i=1 at rising edge SHALL force IDLE, idx=0, k=0, accumulator=0, bmu_valid_o=0, bmu_result_o=0, bmu_trans_id_o=0.
REQ-026 bmu_ready_o SHALL be 1 in first cycle after reset deasserts.
REQ-027 Reset mid-RUN SHALL discard operation without strobe; reset overrides flush and accept.

Structure
REQ-028 fu_data_t, fu_op (BDEP, BEXT, CLZ, CTZ, PCNT) and TRANS_ID_BITS SHALL come from ariane_pkg.
REQ-029 ariane_pkg SHALL gain localparam int unsigned BMU_LATENCY = 65 for issue/scoreboard use.
REQ-030 State enum SHALL be local to bmu_serial; no sub-module (single datapath + FSM).

Verification
REQ-031 BEXT a=0xF0F0, b=0xFF00, trans_id=3 -> result 0xF0, trans_id 3, valid_o exactly cycle 65.
REQ-032 BDEP a=0xAB, b=0xFF00 -> result 0xAB00; ready_o low cycles 1..65, high cycle 66.
REQ-033 CLZ a=0x1_0000 -> 47; CTZ a=0 -> 64; PCNT a=all-ones -> 64.
REQ-034 Issue BEXT, flush_i at cycle 30 -> no valid_o ever for it; ready_o=1 cycle 31; new PCNT a=0x7 accepted -> 3 at 65 cycles later.
REQ-035 rst_i at cycle 40 of RUN -> no strobe, all outputs 0; valid_i held high in IDLE with flush_i=1 -> no accept.
REQ-036 Back-to-back issue with valid_i held high -> second accept in cycle 66, results 66 cycles apart, trans_ids distinct and in order.
